// File: rtl/alu_wb_queue_if.sv
// rtl/alu_wb_queue_if.sv - ALU completion / writeback handshake bundle for alu_wb_queue
interface alu_wb_queue_if #(
    parameter int XLEN                 = 64,
    parameter int PHY_REG_ADDR_WIDTH   = 6,
    parameter int ROB_INDEX_WIDTH      = 6,
    parameter int EXCEPTION_CODE_WIDTH = 4
);
    // ALU completion side
    logic                            alu_done_i;
    logic [PHY_REG_ADDR_WIDTH-1:0]   alu_rd_addr_i;
    logic [ROB_INDEX_WIDTH-1:0]      alu_rob_index_i;
    logic [XLEN-1:0]                 alu_result_i;
    logic                            alu_exception_valid_i;
    logic [EXCEPTION_CODE_WIDTH-1:0] alu_ecause_i;
    logic                            alu_stall_o;

    // Writeback side
    logic                            wb_valid_o;
    logic                            wb_ready_i;
    logic                            wb_rf_we_o;
    logic [PHY_REG_ADDR_WIDTH-1:0]   wb_rd_addr_o;
    logic [XLEN-1:0]                 wb_data_o;
    logic [ROB_INDEX_WIDTH-1:0]      wb_rob_index_o;
    logic                            wb_exception_valid_o;
    logic [EXCEPTION_CODE_WIDTH-1:0] wb_ecause_o;

    // Driver of ALU results and consumer of writebacks
    modport master (
        output alu_done_i, alu_rd_addr_i, alu_rob_index_i, alu_result_i,
               alu_exception_valid_i, alu_ecause_i, wb_ready_i,
        input  alu_stall_o, wb_valid_o, wb_rf_we_o, wb_rd_addr_o, wb_data_o,
               wb_rob_index_o, wb_exception_valid_o, wb_ecause_o
    );

    // The queue itself
    modport slave (
        input  alu_done_i, alu_rd_addr_i, alu_rob_index_i, alu_result_i,
               alu_exception_valid_i, alu_ecause_i, wb_ready_i,
        output alu_stall_o, wb_valid_o, wb_rf_we_o, wb_rd_addr_o, wb_data_o,
               wb_rob_index_o, wb_exception_valid_o, wb_ecause_o
    );
endinterface

// File: rtl/alu_wb_queue.sv
// rtl/alu_wb_queue.sv - circular FIFO between ALU completion and writeback; optional combinational bypass under ALU_WB_BYPASS_EN
module alu_wb_queue #(
    parameter int XLEN                 = 64,
    parameter int PHY_REG_ADDR_WIDTH   = 6,
    parameter int ROB_INDEX_WIDTH      = 6,
    parameter int EXCEPTION_CODE_WIDTH = 4,
    parameter int DEPTH                = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    alu_wb_queue_if.slave            bus,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Entry storage is not reset: validity is tracked by r_count alone
    logic [XLEN-1:0]                 r_data_mem   [DEPTH];
    logic [PHY_REG_ADDR_WIDTH-1:0]   r_rd_mem     [DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]      r_rob_mem    [DEPTH];
    logic                            r_exc_mem    [DEPTH];
    logic [EXCEPTION_CODE_WIDTH-1:0] r_ecause_mem [DEPTH];

    logic                            w_full;
    logic                            w_empty;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_bypass_take;
    logic                            w_head_valid;
    logic [XLEN-1:0]                 w_head_data;
    logic [PHY_REG_ADDR_WIDTH-1:0]   w_head_rd;
    logic [ROB_INDEX_WIDTH-1:0]      w_head_rob;
    logic                            w_head_exc;
    logic [EXCEPTION_CODE_WIDTH-1:0] w_head_ecause;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

`ifdef ALU_WB_BYPASS_EN
    logic w_bypass_valid;

    // With an empty queue the ALU result is presented straight to writeback;
    // if writeback takes it in the same cycle it never enters the queue
    assign w_bypass_valid = w_empty & bus.alu_done_i & ~flush & rstn;
    assign w_bypass_take  = w_bypass_valid & bus.wb_ready_i;
    assign w_head_valid   = w_empty ? w_bypass_valid             : 1'b1;
    assign w_head_data    = w_empty ? bus.alu_result_i           : r_data_mem[r_rd_ptr];
    assign w_head_rd      = w_empty ? bus.alu_rd_addr_i          : r_rd_mem[r_rd_ptr];
    assign w_head_rob     = w_empty ? bus.alu_rob_index_i        : r_rob_mem[r_rd_ptr];
    assign w_head_exc     = w_empty ? bus.alu_exception_valid_i  : r_exc_mem[r_rd_ptr];
    assign w_head_ecause  = w_empty ? bus.alu_ecause_i           : r_ecause_mem[r_rd_ptr];
`else
    // Head is always the oldest stored entry, visible the cycle after its push
    assign w_bypass_take  = 1'b0;
    assign w_head_valid   = ~w_empty;
    assign w_head_data    = r_data_mem[r_rd_ptr];
    assign w_head_rd      = r_rd_mem[r_rd_ptr];
    assign w_head_rob     = r_rob_mem[r_rd_ptr];
    assign w_head_exc     = r_exc_mem[r_rd_ptr];
    assign w_head_ecause  = r_ecause_mem[r_rd_ptr];
`endif

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early
    assign w_push = bus.alu_done_i & ~w_full & ~flush & ~w_bypass_take;
    assign w_pop  = ~w_empty & bus.wb_ready_i & ~flush;

    assign bus.alu_stall_o          = w_full;
    assign bus.wb_valid_o           = w_head_valid;
    assign bus.wb_rf_we_o           = w_head_valid & ~w_head_exc & (w_head_rd != '0);
    assign bus.wb_rd_addr_o         = w_head_rd;
    assign bus.wb_data_o            = w_head_data;
    assign bus.wb_rob_index_o       = w_head_rob;
    assign bus.wb_exception_valid_o = w_head_exc;
    assign bus.wb_ecause_o          = w_head_ecause;
    assign count_o                  = r_count;

    // Pointer and occupancy bookkeeping; flush empties the queue and drops same-cycle traffic
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture all ALU completion fields into the tail slot on push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr]   <= bus.alu_result_i;
            r_rd_mem[r_wr_ptr]     <= bus.alu_rd_addr_i;
            r_rob_mem[r_wr_ptr]    <= bus.alu_rob_index_i;
            r_exc_mem[r_wr_ptr]    <= bus.alu_exception_valid_i;
            r_ecause_mem[r_wr_ptr] <= bus.alu_ecause_i;
        end
    end
endmodule

// File: tb/tb_alu_wb_queue.sv
// tb/tb_alu_wb_queue.sv - scoreboard bench for alu_wb_queue (default build)
module tb_alu_wb_queue;
    localparam int DEPTH = 4;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] count_o;

    alu_wb_queue_if #(.XLEN(64), .PHY_REG_ADDR_WIDTH(6), .ROB_INDEX_WIDTH(6),
                      .EXCEPTION_CODE_WIDTH(4)) bus ();

    alu_wb_queue #(.XLEN(64), .PHY_REG_ADDR_WIDTH(6), .ROB_INDEX_WIDTH(6),
                   .EXCEPTION_CODE_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .bus     (bus),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  rd;
        logic [5:0]  rob;
        logic        exc;
        logic [3:0]  ec;
    } ent_t;

    ent_t sb[$];
    bit   m_full   = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endfunction

    // Reference model, push side: an ALU completion enters the queue unless full or flushed
    always @(posedge clk) begin
        if (rstn && bus.alu_done_i && !flush && !m_full)
            sb.push_back('{bus.alu_result_i, bus.alu_rd_addr_i, bus.alu_rob_index_i,
                           bus.alu_exception_valid_i, bus.alu_ecause_i});
    end

    // Monitor: compare DUT against the model mid-cycle, then apply the upcoming edge's pop/flush
    always @(negedge clk) begin
        int   sz;
        ent_t h;
        sz = sb.size();
        if (!rstn) begin
            sb.delete();
            m_full = 1'b0;
            chk("reset_count", 64'(count_o), 64'(0));
            chk("reset_valid", 64'(bus.wb_valid_o), 64'(0));
            chk("reset_stall", 64'(bus.alu_stall_o), 64'(0));
            chk("reset_rf_we", 64'(bus.wb_rf_we_o), 64'(0));
        end else begin
            chk("count", 64'(count_o), 64'(sz));
            chk("stall", 64'(bus.alu_stall_o), 64'(sz == DEPTH));
            chk("valid", 64'(bus.wb_valid_o), 64'(sz != 0));
            if (sz != 0) begin
                h = sb[0];
                chk("data", bus.wb_data_o, h.data);
                chk("rd", 64'(bus.wb_rd_addr_o), 64'(h.rd));
                chk("rob", 64'(bus.wb_rob_index_o), 64'(h.rob));
                chk("exc", 64'(bus.wb_exception_valid_o), 64'(h.exc));
                chk("ecause", 64'(bus.wb_ecause_o), 64'(h.ec));
                chk("rf_we", 64'(bus.wb_rf_we_o), 64'(!h.exc && h.rd != 6'd0));
            end else begin
                chk("rf_we_empty", 64'(bus.wb_rf_we_o), 64'(0));
            end
            m_full = (sz == DEPTH);
            if (flush) sb.delete();
            else if (sz != 0 && bus.wb_ready_i) void'(sb.pop_front());
        end
    end

    task automatic cyc(input bit done, input logic [5:0] rd, input logic [5:0] rob,
                       input logic [63:0] data, input bit exc, input logic [3:0] ec,
                       input bit rdy, input bit fl);
        bus.alu_done_i            = done;
        bus.alu_rd_addr_i         = rd;
        bus.alu_rob_index_i       = rob;
        bus.alu_result_i          = data;
        bus.alu_exception_valid_i = exc;
        bus.alu_ecause_i          = ec;
        bus.wb_ready_i            = rdy;
        flush                     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cyc(input bit done, input bit rdy, input bit fl);
        cyc(done, 6'($urandom), 6'($urandom), {$urandom, $urandom},
            ($urandom_range(0, 4) == 0), 4'($urandom), rdy, fl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.alu_done_i = 1'b0; bus.alu_rd_addr_i = '0; bus.alu_rob_index_i = '0;
        bus.alu_result_i = '0; bus.alu_exception_valid_i = 1'b0; bus.alu_ecause_i = '0;
        bus.wb_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // single pass
        cyc(1'b1, 6'd5, 6'd3, 64'h1234, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("single_valid", 64'(bus.wb_valid_o), 64'(1));
        chk("single_rf_we", 64'(bus.wb_rf_we_o), 64'(1));
        chk("single_data", bus.wb_data_o, 64'h1234);
        cyc(1'b0, 6'd0, 6'd0, 64'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("single_drained", 64'(count_o), 64'(0));

        // fill, then a held fifth completion that waits for one pop
        for (int i = 0; i < 4; i++) rnd_cyc(1'b1, 1'b0, 1'b0);
        chk("fill_count", 64'(count_o), 64'(4));
        chk("fill_stall", 64'(bus.alu_stall_o), 64'(1));
        for (int i = 0; i < 3; i++) cyc(1'b1, 6'd9, 6'd21, 64'h5555, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("fifth_held", 64'(count_o), 64'(4));
        cyc(1'b1, 6'd9, 6'd21, 64'h5555, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("fifth_after_pop", 64'(count_o), 64'(3));
        cyc(1'b1, 6'd9, 6'd21, 64'h5555, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("fifth_accepted", 64'(count_o), 64'(4));
        for (int i = 0; i < 6; i++) rnd_cyc(1'b0, 1'b1, 1'b0);

        // wrap with back-to-back pushes
        for (int i = 0; i < 10; i++) begin
            rnd_cyc(1'b1, 1'b1, 1'b0);
            chk("wrap_count_le1", 64'(count_o <= 3'd1), 64'(1));
        end
        for (int i = 0; i < 3; i++) rnd_cyc(1'b0, 1'b1, 1'b0);

        // exception entry and x0 destination
        cyc(1'b1, 6'd7, 6'd1, 64'hdead, 1'b1, 4'd2, 1'b0, 1'b0);
        chk("exc_valid", 64'(bus.wb_exception_valid_o), 64'(1));
        chk("exc_cause", 64'(bus.wb_ecause_o), 64'(2));
        chk("exc_rf_we", 64'(bus.wb_rf_we_o), 64'(0));
        cyc(1'b1, 6'd0, 6'd2, 64'hbeef, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 6'd0, 64'h0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("x0_valid", 64'(bus.wb_valid_o), 64'(1));
        chk("x0_rf_we", 64'(bus.wb_rf_we_o), 64'(0));
        for (int i = 0; i < 2; i++) rnd_cyc(1'b0, 1'b1, 1'b0);

        // flush with a completion in the same cycle
        for (int i = 0; i < 3; i++) rnd_cyc(1'b1, 1'b0, 1'b0);
        chk("preflush_count", 64'(count_o), 64'(3));
        rnd_cyc(1'b1, 1'b1, 1'b1);
        chk("flush_count", 64'(count_o), 64'(0));
        chk("flush_valid", 64'(bus.wb_valid_o), 64'(0));

        // randomized traffic
        for (int i = 0; i < 500; i++)
            rnd_cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 31) == 0));

        // asynchronous reset mid-cycle with two entries queued
        rnd_cyc(1'b0, 1'b0, 1'b1);
        rnd_cyc(1'b1, 1'b0, 1'b0);
        rnd_cyc(1'b1, 1'b0, 1'b0);
        rnd_cyc(1'b0, 1'b0, 1'b0);
        #1;
        chk("prereset_count", 64'(count_o), 64'(2));
        rstn = 1'b0;
        #1;
        chk("async_count", 64'(count_o), 64'(0));
        chk("async_valid", 64'(bus.wb_valid_o), 64'(0));
        chk("async_stall", 64'(bus.alu_stall_o), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 40; i++)
            rnd_cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0), 1'b0);
        for (int i = 0; i < 6; i++) rnd_cyc(1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
